// File: rtl/kf_pkg.sv
// Shared KF package: scheduler state encoding and default word format.
// Used by the R-update path and its engine front ends.
package kf_pkg;

  localparam int KF_N    = 20;
  localparam int KF_FRAC = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting channel at or after ptr,
// wrapping NCH-1 -> 0. One-hot grant plus its index.
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx
);

  int   k;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < NCH; i++) begin
      k = (int'(ptr) + i) % NCH;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = CHW'(k);
      end
    end
  end

endmodule

// File: rtl/r_serial_sched.sv
// Shares one r_serial adaptive-R engine between NCH channels:
// round-robin grant, operand latch, start/wait/timeout, tagged response.
module r_serial_sched
  import kf_pkg::*;
#(
  parameter  int N    = KF_N,
  parameter  int FRAC = KF_FRAC,
  parameter  int NCH  = 4,
  parameter  int TMO  = 16,
  localparam int CHW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   req_ack,
  input  logic [NCH*N-1:0] beta_in,
  input  logic [NCH*N-1:0] s00_in,
  input  logic [NCH*N-1:0] s01_in,
  input  logic [NCH*N-1:0] s10_in,
  input  logic [NCH*N-1:0] s11_in,
  input  logic [NCH*N-1:0] z00_in,
  input  logic [NCH*N-1:0] z10_in,
  input  logic [NCH*N-1:0] zh0_in,
  input  logic [NCH*N-1:0] zh1_in,
  output logic             eng_start,
  output logic [N-1:0]     eng_beta,
  output logic [N-1:0]     eng_s00,
  output logic [N-1:0]     eng_s01,
  output logic [N-1:0]     eng_s10,
  output logic [N-1:0]     eng_s11,
  output logic [N-1:0]     eng_z00,
  output logic [N-1:0]     eng_z10,
  output logic [N-1:0]     eng_zh0,
  output logic [N-1:0]     eng_zh1,
  input  logic             eng_done,
  input  logic [N-1:0]     eng_R11,
  input  logic [N-1:0]     eng_R12,
  input  logic [N-1:0]     eng_R21,
  input  logic [N-1:0]     eng_R22,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CHW-1:0]   rsp_ch,
  output logic             rsp_err,
  output logic [N-1:0]     rsp_R11,
  output logic [N-1:0]     rsp_R12,
  output logic [N-1:0]     rsp_R21,
  output logic [N-1:0]     rsp_R22,
  output logic             busy
);

  localparam int TW = $clog2(TMO + 1);

  sched_st_t      state;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] nxt_ptr;
  logic [NCH-1:0] gnt;
  logic [CHW-1:0] gidx;
  logic [TW-1:0]  tmo_cnt;
  int             base;

  // The scheduler only moves words; FRAC is carried for the engine.
  logic unused_frac;
  assign unused_frac = ^32'(FRAC);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (gnt),
    .grant_idx(gidx)
  );

  assign nxt_ptr = (gidx == CHW'(NCH - 1)) ? '0 : gidx + 1'b1;
  assign base    = int'(gidx) * N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      tmo_cnt   <= '0;
      req_ack   <= '0;
      eng_start <= 1'b0;
      eng_beta  <= '0;
      eng_s00   <= '0;
      eng_s01   <= '0;
      eng_s10   <= '0;
      eng_s11   <= '0;
      eng_z00   <= '0;
      eng_z10   <= '0;
      eng_zh0   <= '0;
      eng_zh1   <= '0;
      rsp_valid <= 1'b0;
      rsp_ch    <= '0;
      rsp_err   <= 1'b0;
      rsp_R11   <= '0;
      rsp_R12   <= '0;
      rsp_R21   <= '0;
      rsp_R22   <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            ptr       <= nxt_ptr;
            rsp_ch    <= gidx;
            eng_beta  <= beta_in[base +: N];
            eng_s00   <= s00_in[base +: N];
            eng_s01   <= s01_in[base +: N];
            eng_s10   <= s10_in[base +: N];
            eng_s11   <= s11_in[base +: N];
            eng_z00   <= z00_in[base +: N];
            eng_z10   <= z10_in[base +: N];
            eng_zh0   <= zh0_in[base +: N];
            eng_zh1   <= zh1_in[base +: N];
            eng_start <= 1'b1;
            req_ack   <= gnt;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          eng_start <= 1'b0;
          req_ack   <= '0;
          tmo_cnt   <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_R11   <= eng_R11;
            rsp_R12   <= eng_R12;
            rsp_R21   <= eng_R21;
            rsp_R22   <= eng_R22;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // This cycle brings the count to TMO: abort.
            if (tmo_cnt == TW'(TMO - 1)) begin
              rsp_R11   <= '0;
              rsp_R12   <= '0;
              rsp_R21   <= '0;
              rsp_R22   <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
